// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared constants for the data-memory port arbiter.
//   - Memory geometry: address, write-data and read-data widths.
//   - Upper bound on the number of core requesters.
//   - Phase encoding for the arbiter FSM. It is kept as plain localparams so
//     that older tools and netlists see a one-bit state.
//   - A helper that sizes index/pointer fields and tolerates a single core.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int ADDR_W    = 12;
    localparam int WDATA_W   = 18;
    localparam int RDATA_W   = 12;
    localparam int MAX_CORES = 8;

    // Arbiter phase: loader owns the port, or cores share it
    localparam logic S_LOAD = 1'b0;
    localparam logic S_RUN  = 1'b1;

    // Width of an index into n requesters. Never returns zero, so a
    // single-core build still has a legal one-bit pointer.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. The scan starts at the requester named by
//   ptr and wraps around. The first requester found with its bit set wins.
//   Ports:
//     req        in   N       request vector
//     ptr        in   IDX_W   first requester to consider
//     gnt        out  N       one-hot grant (all zero when nothing requests)
//     gnt_idx    out  IDX_W   encoded index of the granted requester
//     gnt_valid  out  1       a grant was made this cycle
// -----------------------------------------------------------------------------
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Visit candidates in order ptr, ptr+1, ... (mod N).
    // gnt_valid latches the first hit, so later candidates cannot override it.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand     = (int'(ptr) + k) % N;
            cand_idx = IDX_W'(cand);
            if (!gnt_valid && req[cand_idx]) begin
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
                gnt_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single data-memory port between the matrix loader and
//   NUM_CORES processor cores.
//   - LOAD phase (entered from reset or on load_start): the loader has
//     exclusive write access.
//   - RUN phase (entered on load_done): the cores share the port round-robin,
//     with at most one grant per cycle and no bubbles between grants.
//
//   Optional build macro:
//     DMEM_ARB_STATS_EN  when defined, stall_cnt counts RUN cycles in which a
//                        requesting core was left waiting. It saturates at
//                        16'hFFFF and clears on load_start. When undefined,
//                        stall_cnt is tied to 0. The port list is the same in
//                        both builds.
//
//   Ports:
//     clk, rst_n          clock (posedge), asynchronous active-low reset
//     load_start          pulse: go back to the LOAD phase
//     load_done           pulse: loader finished, go to the RUN phase
//     ld_req/addr/wdata   loader write request, address, data
//     ld_gnt              loader request accepted this cycle
//     core_req/we         per-core request (held until granted), 1=write
//     core_addr/wdata     per-core address/data, core i at [i*W +: W]
//     core_gnt            one-hot grant, combinational
//     core_rvalid         one-hot, read data valid for that core
//     core_rdata          read data, broadcast to all cores
//     mem_we/addr/wdata   drive toward datamemory
//     mem_rdata           datamemory output, one cycle after a read
//     busy_load           high while in the LOAD phase
//     stall_cnt           core stall counter (see macro above)
// -----------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = dmem_arb_pkg::ADDR_W,
    parameter int WDATA_W   = dmem_arb_pkg::WDATA_W,
    parameter int RDATA_W   = dmem_arb_pkg::RDATA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_start,
    input  logic                         load_done,
    input  logic                         ld_req,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [WDATA_W-1:0]           ld_wdata,
    output logic                         ld_gnt,
    input  logic [NUM_CORES-1:0]         core_req,
    input  logic [NUM_CORES-1:0]         core_we,
    input  logic [NUM_CORES*ADDR_W-1:0]  core_addr,
    input  logic [NUM_CORES*WDATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]         core_gnt,
    output logic [NUM_CORES-1:0]         core_rvalid,
    output logic [RDATA_W-1:0]           core_rdata,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WDATA_W-1:0]           mem_wdata,
    input  logic [RDATA_W-1:0]           mem_rdata,
    output logic                         busy_load,
    output logic [15:0]                  stall_cnt
);

    localparam int IDX_W = idx_width(NUM_CORES);

    logic                 state_q,  state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0] rvalid_q, rvalid_d;

    logic                 load_active;
    logic                 run_active;
    logic [NUM_CORES-1:0] pick_req;
    logic [NUM_CORES-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    int                   ptr_next;

    // The grant outputs are combinational. Gating them with rst_n makes every
    // output show its reset value as soon as reset is asserted, without
    // waiting for a clock edge.
    assign load_active = rst_n && (state_q == S_LOAD);
    assign run_active  = rst_n && (state_q == S_RUN);

    // Phase transitions take effect on the next cycle. load_start wins over
    // load_done when both arrive in the same cycle.
    always_comb begin
        state_d = state_q;
        if (load_start) begin
            state_d = S_LOAD;
        end else if (load_done) begin
            state_d = S_RUN;
        end
    end

    // During LOAD the picker sees no requests, so cores get no grants.
    assign pick_req = run_active ? core_req : '0;

    rr_pick #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req       (pick_req),
        .ptr       (rr_ptr_q),
        .gnt       (pick_gnt),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    assign core_gnt = pick_gnt;
    assign ld_gnt   = load_active & ld_req;

    // Memory drive follows the current grant. The loader and the cores are
    // never active in the same phase. An idle port drives zeros, not stale
    // values.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (pick_valid) begin
            mem_we    = core_we[pick_idx];
            mem_addr  = core_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata = core_wdata[pick_idx*WDATA_W +: WDATA_W];
        end
    end

    // After a grant, the pointer moves to the core after the winner, which
    // keeps the arbitration fair. With no grant the pointer stays put.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        ptr_next = int'(pick_idx) + 1;
        if (ptr_next >= NUM_CORES) begin
            ptr_next = 0;
        end
        if (pick_valid) begin
            rr_ptr_d = IDX_W'(ptr_next);
        end
    end

    // A granted read returns its data one cycle later. This is registered
    // independently of the phase, so a read granted in a transition cycle
    // still completes.
    assign rvalid_d = pick_gnt & ~core_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_LOAD;
            rr_ptr_q <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign core_rvalid = rvalid_q;
    assign core_rdata  = mem_rdata;
    assign busy_load   = (state_q == S_LOAD);

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // A RUN cycle counts as a stall when some requesting core was not the
    // one granted. load_start clears the count and takes priority over an
    // increment in the same cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_start) begin
            stall_cnt_d = '0;
        end else if (run_active && ((core_req & ~pick_gnt) != '0)
                     && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
